// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART command front end.
package cmd_pkg;

    // Receive-side command assembly states
    typedef enum logic [1:0] {
        IDLE,
        BYTE2,
        BYTE3,
        HOLD
    } rx_state_t;

    // Transmit-side response states
    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    // Command opcodes carried in cmd[23:16]
    localparam logic [7:0] DUMP_CH  = 8'h01;
    localparam logic [7:0] CFG_GAIN = 8'h02;
    localparam logic [7:0] CFG_TRG  = 8'h03;
    localparam logic [7:0] TRIG_POS = 8'h04;
    localparam logic [7:0] SET_DEC  = 8'h05;
    localparam logic [7:0] WRT_TRG  = 8'h06;
    localparam logic [7:0] WRT_CC   = 8'h07;
    localparam logic [7:0] EEP_WR   = 8'h08;
    localparam logic [7:0] EEP_RD   = 8'h09;

    // Response status bytes
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

endpackage

// File: rtl/resp_tx_ctrl.sv
// Response transmit path: hands one byte to the UART transmitter and
// reports completion when the transmitter signals done.
module resp_tx_ctrl
    import cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] resp_data,
    input  logic       send_resp,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       trmt,
    output logic       resp_sent
);

    tx_state_t  state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       trmt_q, trmt_d;
    logic       resp_sent_q, resp_sent_d;
    logic       tx_done_q;

    // Next-state and pulse generation; requests while busy are dropped
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_d = resp_data;
                    trmt_d    = 1'b1;
                    state_d   = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done && !tx_done_q) begin
                    resp_sent_d = 1'b1;
                    state_d     = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // State, data and pulse registers; tx_done history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
            tx_done_q   <= tx_done;
        end
    end

    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: rtl/cmd_assembler.sv
// Assembles three UART bytes into a 24-bit command with an inter-byte
// timeout, and forwards response bytes to the UART transmitter.
module cmd_assembler
    import cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        cmd_err
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    rx_state_t        state_q, state_d;
    logic [23:0]      cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             clr_q, clr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             take;

    // Receive FSM: capture bytes, run the inter-byte timeout, hold the result.
    // The cycle after a capture ignores rx_rdy because the UART has not yet
    // seen clr_rx_rdy; the counter defaults to zero so every capture and
    // every non-waiting state clears it.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        clr_d     = 1'b0;
        err_d     = 1'b0;
        cnt_d     = '0;
        take      = rx_rdy && !clr_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    cmd_d[23:16] = rx_data;
                    clr_d        = 1'b1;
                    state_d      = BYTE2;
                end
            end
            BYTE2: begin
                if (take) begin
                    cmd_d[15:8] = rx_data;
                    clr_d       = 1'b1;
                    state_d     = BYTE3;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BYTE3: begin
                if (take) begin
                    cmd_d[7:0] = rx_data;
                    clr_d      = 1'b1;
                    cmd_rdy_d  = 1'b1;
                    state_d    = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receive-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            clr_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            clr_q     <= clr_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign clr_rx_rdy = clr_q;
    assign cmd_err    = err_q;

    resp_tx_ctrl u_resp_tx_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .resp_data (resp_data),
        .send_resp (send_resp),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .trmt      (trmt),
        .resp_sent (resp_sent)
    );

endmodule

// File: tb/tb_cmd_assembler.sv
// Bench for cmd_assembler: directed and randomized byte streams checked
// against a queue-based model of three-byte command framing.
module tb_cmd_assembler;

    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        resp_sent;
    logic        cmd_err;

    always #5 clk = ~clk;

    cmd_assembler #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp_data   (resp_data),
        .send_resp   (send_resp),
        .tx_data     (tx_data),
        .trmt        (trmt),
        .tx_done     (tx_done),
        .resp_sent   (resp_sent),
        .cmd_err     (cmd_err)
    );

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    // Cycle-level pulse counters (a stuck pulse counts once per cycle)
    int unsigned clr_cnt = 0, trmt_cnt = 0, sent_cnt = 0, err_cnt = 0;
    always @(posedge clk) begin
        if (clr_rx_rdy === 1'b1) clr_cnt  <= clr_cnt + 1;
        if (trmt === 1'b1)       trmt_cnt <= trmt_cnt + 1;
        if (resp_sent === 1'b1)  sent_cnt <= sent_cnt + 1;
        if (cmd_err === 1'b1)    err_cnt  <= err_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // UART receiver model: present a byte, release it one cycle after the
    // clear pulse is seen (the UART registers clr_rx_rdy)
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got     = 1'b0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (clr_rx_rdy === 1'b1) got = 1'b1;
        end
        check("rx_byte_taken", 32'(got), 32'd1);
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    task automatic ack();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("ack_cmd_rdy_low", 32'(cmd_rdy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd"},        32'(cmd),        32'd0);
        check({tag, "_cmd_rdy"},    32'(cmd_rdy),    32'd0);
        check({tag, "_clr_rx_rdy"}, 32'(clr_rx_rdy), 32'd0);
        check({tag, "_tx_data"},    32'(tx_data),    32'd0);
        check({tag, "_trmt"},       32'(trmt),       32'd0);
        check({tag, "_resp_sent"},  32'(resp_sent),  32'd0);
        check({tag, "_cmd_err"},    32'(cmd_err),    32'd0);
    endtask

    // UART transmitter model plus one response transaction with a
    // rejected second request while busy
    task automatic tx_txn(input logic [7:0] b, input logic [7:0] b2);
        int unsigned t0, s0;
        t0        = trmt_cnt;
        s0        = sent_cnt;
        resp_data = b;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        resp_data = b2;
        check("tx_trmt_pulse", 32'(trmt), 32'd1);
        check("tx_data_load", 32'(tx_data), 32'(b));
        tx_done   = 1'b0;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check("tx_busy_no_trmt", 32'(trmt), 32'd0);
        tick($urandom_range(2, 8));
        check("tx_sent_early", 32'(resp_sent), 32'd0);
        tx_done = 1'b1;
        @(negedge clk);
        check("tx_resp_sent", 32'(resp_sent), 32'd1);
        @(negedge clk);
        check("tx_resp_sent_width", 32'(resp_sent), 32'd0);
        check("tx_data_hold", 32'(tx_data), 32'(b));
        check("tx_trmt_count", trmt_cnt - t0, 32'd1);
        check("tx_sent_count", sent_cnt - s0, 32'd1);
    endtask

    logic [7:0]  q[$];
    logic [23:0] exp_cmd;
    logic [7:0]  b0, b1, b2;
    int unsigned c0, e0, s0, k;
    bit          seen;

    initial begin
        rst_n       = 1'b0;
        rx_rdy      = 1'b0;
        rx_data     = '0;
        clr_cmd_rdy = 1'b0;
        resp_data   = '0;
        send_resp   = 1'b0;
        tx_done     = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Basic command
        c0 = clr_cnt;
        send_byte(8'h02); send_byte(8'h1C); send_byte(8'h00);
        check("basic_cmd", 32'(cmd), 32'h021C00);
        check("basic_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check("basic_clr_count", clr_cnt - c0, 32'd3);
        tick(4);
        check("hold_cmd_stable", 32'(cmd), 32'h021C00);
        check("hold_cmd_rdy", 32'(cmd_rdy), 32'd1);
        ack();

        // Spaced bytes, with a stray acknowledge mid-command
        c0 = clr_cnt;
        send_byte(8'h06); tick(5);
        clr_cmd_rdy = 1'b1; tick(1); clr_cmd_rdy = 1'b0;
        send_byte(8'h11); tick(5);
        send_byte(8'hE2); tick(5);
        check("spaced_cmd", 32'(cmd), 32'h0611E2);
        check("spaced_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check("spaced_clr_count", clr_cnt - c0, 32'd3);
        ack();

        // Fourth byte waits in the UART while the command is held
        send_byte(8'h04); send_byte(8'h55); send_byte(8'hAA);
        c0      = clr_cnt;
        rx_data = 8'h07;
        rx_rdy  = 1'b1;
        tick(10);
        check("hold_no_clr", clr_cnt - c0, 32'd0);
        check("hold_cmd", 32'(cmd), 32'h0455AA);
        check("hold_rdy", 32'(cmd_rdy), 32'd1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("release_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("release_no_same_cycle_clr", 32'(clr_rx_rdy), 32'd0);
        tick(1);
        check("pending_clr", 32'(clr_rx_rdy), 32'd1);
        check("pending_opcode", 32'(cmd[23:16]), 32'h07);
        tick(1);
        rx_rdy = 1'b0;
        send_byte(8'h3C); send_byte(8'h5A);
        check("pending_cmd", 32'(cmd), 32'h073C5A);
        check("pending_clr_count", clr_cnt - c0, 32'd3);
        ack();

        // Timeout after two bytes: error TO cycles after the last capture
        e0 = err_cnt;
        send_byte(8'h08); send_byte(8'h2A);
        seen = 1'b0;
        k    = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(negedge clk);
            if (cmd_err === 1'b1) begin seen = 1'b1; k = i; end
        end
        check("to3_err_seen", 32'(seen), 32'd1);
        check("to3_err_delay", k, TO - 1);
        check("to3_cmd_rdy", 32'(cmd_rdy), 32'd0);
        tick(1);
        check("to3_err_width", 32'(cmd_err), 32'd0);
        check("to3_err_count", err_cnt - e0, 32'd1);
        send_byte(8'h09); send_byte(8'h2A); send_byte(8'h00);
        check("after_to_cmd", 32'(cmd), 32'h092A00);
        check("after_to_rdy", 32'(cmd_rdy), 32'd1);
        ack();

        // Timeout after a single byte
        e0 = err_cnt;
        send_byte(8'h05);
        seen = 1'b0;
        k    = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(negedge clk);
            if (cmd_err === 1'b1) begin seen = 1'b1; k = i; end
        end
        check("to2_err_delay", k, TO - 1);
        tick(1);
        check("to2_err_count", err_cnt - e0, 32'd1);

        // Byte arriving on the timeout cycle wins
        e0 = err_cnt;
        send_byte(8'h03); send_byte(8'h04);
        tick(TO - 2);
        send_byte(8'h05);
        check("edge_win_cmd", 32'(cmd), 32'h030405);
        check("edge_win_rdy", 32'(cmd_rdy), 32'd1);
        check("edge_win_no_err", err_cnt - e0, 32'd0);
        ack();

        // Byte arriving one cycle late starts a new command
        e0 = err_cnt;
        send_byte(8'h03); send_byte(8'h04);
        tick(TO - 1);
        send_byte(8'h05);
        check("edge_late_err", err_cnt - e0, 32'd1);
        check("edge_late_rdy", 32'(cmd_rdy), 32'd0);
        send_byte(8'h06); send_byte(8'h07);
        check("edge_late_cmd", 32'(cmd), 32'h050607);
        ack();

        // Response transmit
        tx_txn(8'hA5, 8'h5A);
        check("tx_ack_byte", 32'(tx_data), 32'hA5);

        // Random commands against the framing model, with concurrent responses
        for (int c = 0; c < 8; c++) begin
            c0 = clr_cnt;
            e0 = err_cnt;
            for (int j = 0; j < 3; j++) begin
                b0 = 8'($urandom_range(0, 255));
                q.push_back(b0);
                send_byte(b0);
                tick($urandom_range(0, 20));
            end
            b0 = q.pop_front();
            b1 = q.pop_front();
            b2 = q.pop_front();
            exp_cmd = {b0, b1, b2};
            check("rand_cmd", 32'(cmd), 32'(exp_cmd));
            check("rand_rdy", 32'(cmd_rdy), 32'd1);
            check("rand_clr_count", clr_cnt - c0, 32'd3);
            check("rand_no_err", err_cnt - e0, 32'd0);
            if (c % 3 == 1) begin
                tx_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                check("rand_tx_cmd_kept", 32'(cmd), 32'(exp_cmd));
                check("rand_tx_rdy_kept", 32'(cmd_rdy), 32'd1);
            end
            tick($urandom_range(0, 4));
            ack();
        end

        // Reset mid-command and mid-transmission
        send_byte(8'h0A); send_byte(8'h0B);
        resp_data = 8'hEE;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        tx_done   = 1'b0;
        tick(2);
        rst_n  = 1'b0;
        rx_rdy = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(2);
        rst_n = 1'b1;
        s0 = sent_cnt;
        e0 = err_cnt;
        tick(2);
        tx_done = 1'b1;
        tick(4);
        check("midreset_no_resp_sent", sent_cnt - s0, 32'd0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        check("post_reset_cmd", 32'(cmd), 32'h010203);
        check("post_reset_rdy", 32'(cmd_rdy), 32'd1);
        check("post_reset_no_err", err_cnt - e0, 32'd0);
        ack();
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
